psram_apb_bridge: RTL and testbench

- APB slave front end for the QSPI PSRAM path, sitting directly upstream of the EBh reader and 38h writer engines.
- Decodes APB transfers (address, byte strobes) into engine commands: rd/wr pulse, 24-bit start address, byte count, and lane-aligned write data.
- Sequences each engine to completion and returns read data and the error response.
- Muxes the two engines' pad signals onto the single QSPI pad set.

---
 rtl/psram_pkg.sv | 53 +++++
 rtl/psram_pad_mux.sv | 25 ++
 rtl/psram_apb_bridge.sv | 156 +++++++++++++++
 tb/tb_psram_apb_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared types for the QSPI PSRAM APB path.
//   state_e     : bridge sequencer states
//   sel_e       : which engine owns the pads
//   pad_t       : one engine's pad bundle {sck, ce_n, dout, douten}
//   strb_decode : APB byte strobes -> {legal, start offset, byte count}
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_GO, ST_RD_WAIT, ST_WR_GO, ST_WR_WAIT, ST_RESP, ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_RD, SEL_WR} sel_e;

  // Quad I/O opcodes shared with the reader/writer engines.
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  typedef struct packed {
    logic       sck;
    logic       ce_n;
    logic [3:0] dout;
    logic       douten;
  } pad_t;

  localparam pad_t PAD_IDLE = '{sck: 1'b0, ce_n: 1'b1, dout: 4'h0, douten: 1'b0};

  typedef struct packed {
    logic       legal;
    logic [1:0] offset;
    logic [2:0] size;
  } strb_info_t;

  // Only a single contiguous run of strobes maps onto one engine burst.
  function automatic strb_info_t strb_decode(input logic [3:0] strb);
    strb_info_t r;
    r = '0;
    case (strb)
      4'b0001: r = {1'b1, 2'd0, 3'd1};
      4'b0010: r = {1'b1, 2'd1, 3'd1};
      4'b0100: r = {1'b1, 2'd2, 3'd1};
      4'b1000: r = {1'b1, 2'd3, 3'd1};
      4'b0011: r = {1'b1, 2'd0, 3'd2};
      4'b0110: r = {1'b1, 2'd1, 3'd2};
      4'b1100: r = {1'b1, 2'd2, 3'd2};
      4'b0111: r = {1'b1, 2'd0, 3'd3};
      4'b1110: r = {1'b1, 2'd1, 3'd3};
      4'b1111: r = {1'b1, 2'd0, 3'd4};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psram_pad_mux.sv
// Combinational pad selector: routes the owning engine's pads to the QSPI
// pins, or parks them idle (sck=0, ce_n=1, no drive) when nobody owns them.
//   sel    : current owner
//   rd_pad : reader pad outputs
//   wr_pad : writer pad outputs
//   pad    : pin-side pad bundle
module psram_pad_mux
  import psram_pkg::*;
(
  input  sel_e sel,
  input  pad_t rd_pad,
  input  pad_t wr_pad,
  output pad_t pad
);

  always_comb begin
    pad = PAD_IDLE;
    case (sel)
      SEL_RD:  pad = rd_pad;
      SEL_WR:  pad = wr_pad;
      default: pad = PAD_IDLE;
    endcase
  end

endmodule

// File: rtl/psram_apb_bridge.sv
// APB slave front end for the QSPI PSRAM reader (EBh) and writer (38h).
// Turns one APB access into one engine command, waits for the engine, then
// answers with pready for one cycle and drains the engine before accepting
// the next access.
//   APB     : psel/penable/pwrite/paddr/pwdata/pstrb in; prdata/pready/pslverr out
//   engines : rd_req/wr_req pulses, eng_addr/eng_size/eng_line command,
//             rd_done/rd_line and wr_done back
//   pads    : rd_* and wr_* pad bundles in, muxed sck/ce_n/dout/douten out
module psram_apb_bridge
  import psram_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int SIZE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              rd_req,
  input  logic              rd_done,
  input  logic [31:0]       rd_line,
  output logic              wr_req,
  input  logic              wr_done,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [SIZE_W-1:0] eng_size,
  output logic [31:0]       eng_line,
  input  logic              rd_sck,
  input  logic              rd_ce_n,
  input  logic [3:0]        rd_dout,
  input  logic              rd_douten,
  input  logic              wr_sck,
  input  logic              wr_ce_n,
  input  logic [3:0]        wr_dout,
  input  logic              wr_douten,
  output logic              sck,
  output logic              ce_n,
  output logic [3:0]        dout,
  output logic              douten
);

  state_e     state_q, state_d;
  sel_e       sel_q;
  strb_info_t si;
  pad_t       rd_pad, wr_pad, pad;
  logic       ld_rd, ld_wr, ld_err, cap_rd, clr;
  logic       sel_done;

  // Byte lanes come from pstrb, so the low address bits and anything above
  // the PSRAM window carry no information here.
  logic unused_bits;
  assign unused_bits = ^{paddr[31:ADDR_W], paddr[1:0]};

  assign si       = strb_decode(pstrb);
  assign rd_pad   = {rd_sck, rd_ce_n, rd_dout, rd_douten};
  assign wr_pad   = {wr_sck, wr_ce_n, wr_dout, wr_douten};
  assign sel_done = (sel_q == SEL_RD) ? rd_done :
                    (sel_q == SEL_WR) ? wr_done : 1'b0;

  psram_pad_mux u_pad_mux (
    .sel    (sel_q),
    .rd_pad (rd_pad),
    .wr_pad (wr_pad),
    .pad    (pad)
  );

  assign sck    = pad.sck;
  assign ce_n   = pad.ce_n;
  assign dout   = pad.dout;
  assign douten = pad.douten;

  assign pready = (state_q == ST_RESP);
  assign rd_req = (state_q == ST_RD_GO);
  assign wr_req = (state_q == ST_WR_GO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_rd   = 1'b0;
    ld_wr   = 1'b0;
    ld_err  = 1'b0;
    cap_rd  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && penable && !pready) begin
          if (!pwrite) begin
            ld_rd   = 1'b1;
            state_d = ST_RD_GO;
          end else if (si.legal) begin
            ld_wr   = 1'b1;
            state_d = ST_WR_GO;
          end else begin
            ld_err  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RD_GO:   state_d = ST_RD_WAIT;
      ST_WR_GO:   state_d = ST_WR_WAIT;
      ST_RD_WAIT: if (rd_done) begin
                    cap_rd  = 1'b1;
                    state_d = ST_RESP;
                  end
      ST_WR_WAIT: if (wr_done) state_d = ST_RESP;
      ST_RESP:    state_d = ST_DRAIN;
      // Engines may hold done for several cycles; restarting before it drops
      // would let the stale done complete the next command early.
      ST_DRAIN:   if (!sel_done && pad.ce_n) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                  end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= SEL_NONE;
      prdata   <= '0;
      pslverr  <= 1'b0;
      eng_addr <= '0;
      eng_size <= '0;
      eng_line <= '0;
    end else begin
      if (ld_rd) begin
        sel_q    <= SEL_RD;
        eng_addr <= {paddr[ADDR_W-1:2], 2'b00};
        eng_size <= SIZE_W'(4);
      end
      if (ld_wr) begin
        sel_q    <= SEL_WR;
        eng_addr <= {paddr[ADDR_W-1:2], si.offset};
        eng_size <= SIZE_W'(si.size);
        eng_line <= pwdata >> {si.offset, 3'b000};
      end
      if (ld_err) pslverr <= 1'b1;
      if (cap_rd) prdata  <= rd_line;
      if (clr) begin
        sel_q   <= SEL_NONE;
        pslverr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psram_apb_bridge.sv
module tb_psram_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        rd_req, rd_done, wr_req, wr_done;
  logic [31:0] rd_line;
  logic [23:0] eng_addr;
  logic [2:0]  eng_size;
  logic [31:0] eng_line;
  logic        rd_sck, rd_ce_n, rd_douten, wr_sck, wr_ce_n, wr_douten;
  logic [3:0]  rd_dout, wr_dout;
  logic        sck, ce_n, douten;
  logic [3:0]  dout;

  always #5 clk = ~clk;

  psram_apb_bridge dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .rd_req(rd_req), .rd_done(rd_done),
    .rd_line(rd_line), .wr_req(wr_req), .wr_done(wr_done), .eng_addr(eng_addr),
    .eng_size(eng_size), .eng_line(eng_line), .rd_sck(rd_sck), .rd_ce_n(rd_ce_n),
    .rd_dout(rd_dout), .rd_douten(rd_douten), .wr_sck(wr_sck), .wr_ce_n(wr_ce_n),
    .wr_dout(wr_dout), .wr_douten(wr_douten), .sck(sck), .ce_n(ce_n),
    .dout(dout), .douten(douten)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    bit          is_rd;
    bit          err;
    int          nreq;
    logic [23:0] addr;
    logic [2:0]  size;
    logic [31:0] line;
    logic [31:0] rdata;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] ref_mem[int];   // what APB has written, byte addressed
  bit [7:0] dev_mem[int];   // what the emulated PSRAM actually holds
  int       lat  = 3;
  int       hold = 1;
  int       checks = 0;
  int       errors = 0;
  logic     rst_chk = 1'b0;

  function automatic bit [7:0] ref_byte(int k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction
  function automatic bit [7:0] dev_byte(int k);
    return dev_mem.exists(k) ? dev_mem[k] : 8'h00;
  endfunction

  // ---------------- engine emulators ----------------
  int          r_cnt, r_hold, w_cnt, w_hold;
  logic [23:0] r_addr, w_addr;
  logic [2:0]  r_size, w_size;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ce_n <= 1; rd_sck <= 0; rd_dout <= 0; rd_douten <= 0;
      rd_done <= 0; rd_line <= 0; r_cnt <= 0; r_hold <= 0;
    end else if (rd_req) begin
      r_cnt <= lat; rd_ce_n <= 0; r_addr <= eng_addr; r_size <= eng_size;
    end else if (r_cnt > 0) begin
      if (r_cnt == 1) begin
        rd_ce_n <= 1; rd_sck <= 0; rd_dout <= 0; rd_douten <= 0;
        rd_done <= 1; r_hold <= hold;
        rd_line <= {dev_byte(int'(r_addr) + 3), dev_byte(int'(r_addr) + 2),
                    dev_byte(int'(r_addr) + 1), dev_byte(int'(r_addr))};
      end else begin
        rd_sck <= ~rd_sck; rd_dout <= 4'($urandom); rd_douten <= 1;
      end
      r_cnt <= r_cnt - 1;
    end else if (rd_done) begin
      if (r_hold <= 1) rd_done <= 0;
      r_hold <= r_hold - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ce_n <= 1; wr_sck <= 0; wr_dout <= 0; wr_douten <= 0;
      wr_done <= 0; w_cnt <= 0; w_hold <= 0;
    end else if (wr_req) begin
      w_cnt <= lat; wr_ce_n <= 0; w_addr <= eng_addr; w_size <= eng_size;
      for (int i = 0; i < int'(eng_size); i++)
        dev_mem[int'(eng_addr) + i] = eng_line[8*i +: 8];
    end else if (w_cnt > 0) begin
      if (w_cnt == 1) begin
        wr_ce_n <= 1; wr_sck <= 0; wr_dout <= 0; wr_douten <= 0;
        wr_done <= 1; w_hold <= hold;
      end else begin
        wr_sck <= ~wr_sck; wr_dout <= 4'($urandom); wr_douten <= 1;
      end
      w_cnt <= w_cnt - 1;
    end else if (wr_done) begin
      if (w_hold <= 1) wr_done <= 0;
      w_hold <= w_hold - 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  int   reqs_seen;
  logic rd_done_q, wr_done_q, rise_q, pready_q;
  exp_t e;

  always @(negedge clk or posedge rst_chk) begin
    if (rst_chk) begin
      chk("rst_pready", pready, 0);
      chk("rst_pslverr", pslverr, 0);
      chk("rst_prdata", prdata, 0);
      chk("rst_req", {rd_req, wr_req}, 0);
      chk("rst_eng", {eng_addr, eng_size, eng_line}, 0);
      chk("rst_pads", {sck, ce_n, dout, douten}, 7'b0100000);
      exp_q.delete();
      reqs_seen = 0; rd_done_q = 0; wr_done_q = 0; rise_q = 0; pready_q = 0;
    end else if (rst_n) begin
      if (!rd_ce_n) chk("pad_rd", {sck, ce_n, dout, douten}, {rd_sck, rd_ce_n, rd_dout, rd_douten});
      if (!wr_ce_n) chk("pad_wr", {sck, ce_n, dout, douten}, {wr_sck, wr_ce_n, wr_dout, wr_douten});
      if (rd_ce_n && wr_ce_n) chk("pad_idle", {sck, ce_n, dout, douten}, 7'b0100000);
      if (rd_req || wr_req) begin
        if (exp_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          e = exp_q[0];
          chk("req_kind", {rd_req, wr_req}, {e.is_rd, !e.is_rd});
          chk("req_addr", eng_addr, e.addr);
          chk("req_size", eng_size, e.size);
          if (!e.is_rd) chk("req_line", eng_line, e.line);
        end
        chk("req_done_low", {rd_done, wr_done}, 0);
        reqs_seen++;
      end
      if (rise_q) chk("resp_latency", pready, 1);
      if (pready) begin
        chk("pready_one_cycle", pready_q, 0);
        chk("pready_not_busy", {rd_ce_n, wr_ce_n}, 2'b11);
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pslverr", pslverr, e.err);
          chk("req_count", reqs_seen, e.nreq);
          if (e.is_rd) chk("prdata", prdata, e.rdata);
        end
        reqs_seen = 0;
      end
      if (rd_done && !rd_done_q) chk("eng_stable_rd", {eng_addr, eng_size}, {r_addr, r_size});
      if (wr_done && !wr_done_q) chk("eng_stable_wr", {eng_addr, eng_size}, {w_addr, w_size});
      rise_q    = (rd_done && !rd_done_q) || (wr_done && !wr_done_q);
      rd_done_q = rd_done;
      wr_done_q = wr_done;
      pready_q  = pready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    exp_t x;
    int   off;
    bit   ok;
    int   base;
    base   = int'({a[23:2], 2'b00});
    x.is_rd = !wr;
    x.line  = 'x;
    if (!wr) begin
      x.err = 0; x.nreq = 1; x.addr = 24'(base); x.size = 4;
      x.rdata = {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
    end else begin
      x.err  = !(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                           4'b0110, 4'b1100, 4'b0111, 4'b1110, 4'b1111});
      x.nreq = x.err ? 0 : 1;
      off = 0;
      for (int i = 3; i >= 0; i--) if (s[i]) off = i;
      x.addr  = 24'(base + off);
      x.size  = 3'($countones(s));
      x.line  = d >> (8 * off);
      x.rdata = 0;
      if (!x.err)
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[base + i] = d[8*i +: 8];
    end
    exp_q.push_back(x);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = wr ? s : 4'h0;
    @(posedge clk); #1;
    penable = 1;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pready) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL apb_timeout act=no_pready exp=pready addr=%0h", a);
      $fatal(1, "bridge hung");
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  initial begin
    bit found;
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    #3 rst_chk = 1;
    #1 rst_chk = 0;
    #23 rst_n = 1;

    // directed cases
    apb(1, 32'h0000_0104, 32'h4433_2211, 4'b1111);
    apb(0, 32'h8000_0106, 32'h0, 4'h0);
    apb(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    apb(1, 32'h0000_0020, 32'h00AB_CD00, 4'b0110);
    apb(1, 32'h0000_0030, 32'h1234_5678, 4'b0101);
    apb(1, 32'h0000_0034, 32'h1234_5678, 4'b0000);
    apb(1, 32'h0000_0027, 32'h9900_0000, 4'b1000);
    apb(0, 32'h0000_0020, 32'h0, 4'h0);
    hold = 2;
    apb(0, 32'h0000_0010, 32'h0, 4'h0);
    apb(1, 32'h0000_0014, 32'hCAFE_F00D, 4'b0111);
    hold = 3;
    apb(0, 32'h0000_0014, 32'h0, 4'h0);
    apb(1, 32'h0000_0018, 32'h5566_7788, 4'b1110);

    // randomized traffic over a small window so reads revisit written bytes
    for (int t = 0; t < 40; t++) begin
      lat  = $urandom_range(2, 6);
      hold = $urandom_range(1, 3);
      apb(1'($urandom_range(0, 1)), ($urandom & 32'hFF00_0000) | $urandom_range(0, 63),
          $urandom, 4'($urandom_range(0, 15)));
    end

    // async reset while the reader is busy
    lat = 8; hold = 1;
    exp_q.push_back('{is_rd: 1, err: 0, nreq: 1, addr: 24'h40, size: 3'd4,
                      line: 32'h0, rdata: 32'h0});
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h40;
    @(posedge clk); #1;
    penable = 1;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rd_req) begin found = 1; break; end
    end
    if (!found) begin
      $display("FAIL rd_req_timeout act=0 exp=1");
      $fatal(1, "no read request");
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1 rst_chk = 1;
    #1 rst_chk = 0;
    psel = 0; penable = 0;
    @(posedge clk); #2 rst_n = 1;

    lat = 3;
    apb(0, 32'h0000_0040, 32'h0, 4'h0);
    apb(0, 32'h8000_0106, 32'h0, 4'h0);
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
